// File: rtl/crf_tree_walker.sv
// Sequencer for one Compact Random Forest tree: shares one node-threshold SRAM port
// between node loading and root-to-leaf inference walks.
module crf_tree_walker #(
  parameter int STAGES = 5,
  parameter int FEAT_W = 8,
  parameter int THR_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              loadValid,
  output logic              loadReady,
  input  logic [STAGES-1:0] loadAddr,
  input  logic [31:0]       loadData,
  input  logic              startValid,
  output logic              startReady,
  output logic [FEAT_W-1:0] featureSel,
  input  logic [THR_W-1:0]  featureVal,
  output logic              resultValid,
  input  logic              resultReady,
  output logic [STAGES-1:0] resultLeaf,
  output logic              busy,
  output logic              sramCellEnable,
  output logic              sramWriteEnable,
  output logic [STAGES-1:0] sramNodeIndex,
  output logic [31:0]       sramInData,
  input  logic [31:0]       sramOutData
);

  localparam int NODES = 2**STAGES - 1;
  localparam int LVL_W = $clog2(STAGES + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_COMPARE, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [STAGES:0]    r_idx;
  logic [LVL_W-1:0]   r_level;
  logic [31:0]        r_nodeWord;
  logic [STAGES-1:0]  r_ldAddr;
  logic [31:0]        r_ldData;
  logic [STAGES-1:0]  r_leaf;

  logic               w_addrOk;
  logic               w_goRight;
  logic [STAGES:0]    w_newIdx;
  logic [LVL_W-1:0]   w_newLevel;
  logic               w_lastLevel;
  logic [STAGES-1:0]  w_leaf;

  // The only out-of-range node address is the all-ones value.
  assign w_addrOk    = ~&r_ldAddr;
  assign w_goRight   = (featureVal >= r_nodeWord[THR_W-1:0]);
  assign w_newIdx    = (r_idx << 1) + {{(STAGES-1){1'b0}}, w_goRight, ~w_goRight};
  assign w_newLevel  = r_level + 1'b1;
  assign w_lastLevel = (w_newLevel == LVL_W'(STAGES));
  // Leaf = newIdx - (2^STAGES-1); modulo 2^STAGES this is the low bits plus one.
  assign w_leaf      = w_newIdx[STAGES-1:0] - STAGES'(NODES);

  always_comb begin
    w_next          = r_state;
    loadReady       = 1'b0;
    startReady      = 1'b0;
    featureSel      = '0;
    resultValid     = 1'b0;
    resultLeaf      = r_leaf;
    busy            = (r_state != S_IDLE);
    sramCellEnable  = 1'b0;
    sramWriteEnable = 1'b0;
    sramNodeIndex   = '0;
    sramInData      = '0;
    case (r_state)
      S_IDLE: begin
        loadReady  = 1'b1;
        startReady = !loadValid;
        if (loadValid)       w_next = S_LOAD;
        else if (startValid) w_next = S_FETCH;
      end
      S_LOAD: begin
        sramCellEnable  = w_addrOk;
        sramWriteEnable = w_addrOk;
        sramNodeIndex   = w_addrOk ? r_ldAddr : '0;
        sramInData      = w_addrOk ? r_ldData : '0;
        w_next          = S_IDLE;
      end
      S_FETCH: begin
        sramCellEnable = 1'b1;
        sramNodeIndex  = r_idx[STAGES-1:0];
        w_next         = S_COMPARE;
      end
      S_COMPARE: begin
        featureSel = r_nodeWord[31 -: FEAT_W];
        w_next     = w_lastLevel ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        resultValid = 1'b1;
        if (resultReady) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_level    <= '0;
      r_nodeWord <= '0;
      r_ldAddr   <= '0;
      r_ldData   <= '0;
      r_leaf     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (loadValid) begin
            r_ldAddr <= loadAddr;
            r_ldData <= loadData;
          end else if (startValid) begin
            r_idx   <= '0;
            r_level <= '0;
          end
        end
        S_FETCH: r_nodeWord <= sramOutData;
        S_COMPARE: begin
          r_idx   <= w_newIdx;
          r_level <= w_newLevel;
          if (w_lastLevel) r_leaf <= w_leaf;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crf_tree_walker.sv
// Self-checking bench for crf_tree_walker: SRAM and feature-buffer models, table vectors,
// hand-written corner sequences and randomized walks against a decision-path model.
module tb_crf_tree_walker;
  localparam int S = 5;
  localparam int NODES = 2**S - 1;

  logic         clk, rst_n;
  logic         loadValid, loadReady, startValid, startReady;
  logic [S-1:0] loadAddr;
  logic [31:0]  loadData;
  logic [7:0]   featureSel;
  logic [23:0]  featureVal;
  logic         resultValid, resultReady, busy;
  logic [S-1:0] resultLeaf;
  logic         sramCellEnable, sramWriteEnable;
  logic [S-1:0] sramNodeIndex;
  logic [31:0]  sramInData, sramOutData;

  crf_tree_walker #(.STAGES(S), .FEAT_W(8), .THR_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .loadValid(loadValid), .loadReady(loadReady), .loadAddr(loadAddr), .loadData(loadData),
    .startValid(startValid), .startReady(startReady),
    .featureSel(featureSel), .featureVal(featureVal),
    .resultValid(resultValid), .resultReady(resultReady), .resultLeaf(resultLeaf),
    .busy(busy),
    .sramCellEnable(sramCellEnable), .sramWriteEnable(sramWriteEnable),
    .sramNodeIndex(sramNodeIndex), .sramInData(sramInData), .sramOutData(sramOutData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem   [0:31];
  logic [23:0] fbuf  [0:255];
  logic [31:0] mnode [0:NODES-1];
  int          rd_path[$];
  int          exp_path[$];
  int          n_chk = 0;
  int          n_fail = 0;
  bit          mon_on = 1'b0;

  assign sramOutData = sramCellEnable ? mem[sramNodeIndex] : 32'hzzzz_zzzz;
  assign featureVal  = fbuf[featureSel];

  always @(posedge clk)
    if (sramCellEnable && sramWriteEnable) mem[sramNodeIndex] <= sramInData;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sramCellEnable && !sramWriteEnable) rd_path.push_back(int'(sramNodeIndex));
    if (mon_on && (sramCellEnable || sramWriteEnable))
      chk("we_without_ce", {63'd0, sramWriteEnable & ~sramCellEnable}, 64'd0);
  end

  // Reference: each level's decision is one leaf bit, MSB first; the read path is the heap walk.
  task automatic model(output logic [S-1:0] leaf);
    int idx;
    logic [31:0] w;
    logic dir;
    exp_path.delete();
    idx = 0;
    leaf = '0;
    for (int l = 0; l < S; l++) begin
      exp_path.push_back(idx);
      w = mnode[idx];
      dir = (fbuf[w[31:24]] >= w[23:0]);
      leaf = {leaf[S-2:0], dir};
      idx = 2 * idx + 1 + int'(dir);
    end
  endtask

  task automatic load_node(input logic [S-1:0] a, input logic [31:0] d);
    loadValid = 1'b1; loadAddr = a; loadData = d;
    @(posedge clk); #1;
    loadValid = 1'b0;
    if (a != S'(NODES)) mnode[a] = d;
    @(posedge clk); #1;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!resultValid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_path(input string nm);
    chk({nm, "_pathlen"}, rd_path.size(), exp_path.size());
    for (int i = 0; i < exp_path.size() && i < rd_path.size(); i++)
      chk({nm, "_path"}, rd_path[i], exp_path[i]);
  endtask

  task automatic run_walk(input string nm, input logic [S-1:0] exp_leaf);
    int lat;
    rd_path.delete();
    startValid = 1'b1;
    @(posedge clk); #1;
    startValid = 1'b0;
    wait_result(lat);
    chk({nm, "_latency"}, lat, 11);
    chk({nm, "_leaf"}, resultLeaf, exp_leaf);
    check_path(nm);
    resultReady = 1'b1;
    @(posedge clk); #1;
    resultReady = 1'b0;
    chk({nm, "_valid_drop"}, resultValid, 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  typedef struct {
    logic [23:0]  fval;
    logic [S-1:0] leaf;
  } vec_t;
  vec_t tbl[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [S-1:0] ml, held;
    logic [31:0]  d;
    int           lat, seen;

    tbl[0] = '{fval: 24'd50,  leaf: 5'd0};
    tbl[1] = '{fval: 24'd100, leaf: 5'd31};
    tbl[2] = '{fval: 24'd99,  leaf: 5'd0};
    tbl[3] = '{fval: 24'd255, leaf: 5'd31};

    for (int i = 0; i < 32; i++) mem[i] = '0;
    for (int i = 0; i < NODES; i++) mnode[i] = '0;
    for (int i = 0; i < 256; i++) fbuf[i] = '0;
    rst_n = 1'b0; loadValid = 1'b0; loadAddr = '0; loadData = '0;
    startValid = 1'b1; resultReady = 1'b0;

    // Reset held for two cycles with a pending start request
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk("reset_outputs", {10'd0, resultValid, resultLeaf, featureSel, sramCellEnable,
          sramWriteEnable, sramNodeIndex, sramInData, busy}, 64'd0);
    end
    rst_n = 1'b1; startValid = 1'b0;
    #1;
    chk("reset_startReady", startReady, 1);
    chk("reset_loadReady", loadReady, 1);
    mon_on = 1'b1;

    // Uniform feature values against threshold 100 at every node
    for (int i = 0; i < NODES; i++) load_node(S'(i), {8'(i), 24'd100});
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < 256; i++) fbuf[i] = tbl[v].fval;
      model(ml);
      run_walk($sformatf("table%0d", v), tbl[v].leaf);
    end

    // Mixed path: right at root, then left, left, left, right
    load_node(5'd0,  {8'd0,  24'd10});
    load_node(5'd2,  {8'd2,  24'd50});
    load_node(5'd5,  {8'd5,  24'd100});
    load_node(5'd11, {8'd11, 24'd100});
    load_node(5'd23, {8'd23, 24'd100});
    for (int i = 0; i < 256; i++) fbuf[i] = '0;
    fbuf[0] = 24'd20; fbuf[2] = 24'd5; fbuf[23] = 24'd200;
    model(ml);
    run_walk("mixed", 5'd17);

    // Load and start requested together: load first
    loadValid = 1'b1; loadAddr = 5'd3; loadData = {8'd3, 24'd7}; startValid = 1'b1;
    #1;
    chk("arb_startReady_blocked", startReady, 0);
    @(posedge clk); #1;
    loadValid = 1'b0;
    mnode[3] = {8'd3, 24'd7};
    chk("arb_load_we", {sramCellEnable, sramWriteEnable}, 2'b11);
    chk("arb_load_idx", sramNodeIndex, 3);
    chk("arb_load_data", sramInData, {8'd3, 24'd7});
    chk("arb_load_busy_noStart", {busy, startReady}, 2'b10);
    @(posedge clk); #1;
    chk("arb_idle_startReady", startReady, 1);
    model(ml);
    run_walk("arb_walk", ml);

    // Out-of-range load address is dropped
    loadValid = 1'b1; loadAddr = 5'd31; loadData = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    loadValid = 1'b0;
    chk("drop_no_enable", {sramCellEnable, sramWriteEnable}, 2'b00);
    chk("drop_busy", busy, 1);
    @(posedge clk); #1;
    chk("drop_back_idle", busy, 0);

    // Backpressure: result held while requests are refused
    model(ml);
    startValid = 1'b1;
    @(posedge clk); #1;
    startValid = 1'b0;
    wait_result(lat);
    chk("bp_latency", lat, 11);
    held = resultLeaf;
    chk("bp_leaf", held, ml);
    loadValid = 1'b1; loadAddr = 5'd1; loadData = 32'h0; startValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk("bp_hold", {resultValid, resultLeaf, startReady, loadReady}, {1'b1, held, 2'b00});
    end
    loadValid = 1'b0; startValid = 1'b0; resultReady = 1'b1;
    @(posedge clk); #1;
    resultReady = 1'b0;
    chk("bp_release", {resultValid, busy}, 2'b00);

    // Reset during COMPARE aborts the walk
    model(ml);
    startValid = 1'b1;
    @(posedge clk); #1;
    startValid = 1'b0;
    @(posedge clk); #1;
    chk("abort_featureSel", featureSel, mnode[exp_path[0]][31:24]);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_idle", {busy, resultValid, sramCellEnable, resultLeaf}, 0);
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (resultValid || busy) seen++;
    end
    chk("abort_no_result", seen, 0);

    // Randomized trees and feature buffers
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 256; i++) fbuf[i] = 24'($urandom);
      for (int i = 0; i < NODES; i++) begin
        d[31:24] = 8'($urandom_range(0, 255));
        d[23:0]  = ($urandom_range(0, 3) == 0) ? fbuf[d[31:24]] : 24'($urandom);
        load_node(S'(i), d);
      end
      model(ml);
      run_walk($sformatf("rand%0d", t), ml);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
